// File: rtl/dram_arbiter.sv
// Two-requester arbiter for a shared 8-lane DRAM port.
// Requester 0 is fetch and requester 1 is ser_aggregate. The holder's lanes go
// straight through to the DRAM port, and completions route back only to the holder.
// The grant never moves while a lane is still waiting on a completion. The grant
// is handed over when the holder goes quiet. It is also handed over when the
// holder has held for HOLD_MAX cycles and the other requester is waiting.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no grant; DRAM port driven to zero
// GNT0    | requester 0 (fetch) owns the DRAM port
// GNT1    | requester 1 (ser_aggregate) owns the DRAM port
module dram_arbiter #(
  parameter int HOLD_MAX = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0]       req0_en,
  input  logic             req0_rdwr,
  input  logic [7:0][63:0] req0_addr,
  input  logic [7:0][7:0]  req0_wdata,
  output logic [7:0]       req0_valid,
  output logic [7:0][7:0]  req0_rdata,
  input  logic [7:0]       req1_en,
  input  logic             req1_rdwr,
  input  logic [7:0][63:0] req1_addr,
  input  logic [7:0][7:0]  req1_wdata,
  output logic [7:0]       req1_valid,
  output logic [7:0][7:0]  req1_rdata,
  output logic [7:0]       dram_en,
  output logic             dram_rdwr,
  output logic [7:0][63:0] dram_addr,
  output logic [7:0][7:0]  data_to_dram,
  input  logic [7:0]       dram_valid,
  input  logic [7:0][7:0]  data_from_dram,
  output logic [1:0]       gnt,
  output logic             busy
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("dram_arbiter: HOLD_MAX must be within 1..255");
  end

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       last_served_q, last_served_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] out_q, out_d;

  logic       req0_act;
  logic       req1_act;
  logic       out_empty;
  logic       hold_expired;
  logic       grant_change;

  assign req0_act     = |req0_en;
  assign req1_act     = |req1_en;
  assign out_empty    = (out_q == 8'h00);
  assign hold_expired = (hold_q >= HOLD_MAX_C);
  assign gnt          = gnt_q;
  assign busy         = busy_q;

  // Next grant decision: arbitrate from idle, release on quiet, preempt on long hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (req0_act && req1_act) begin
            state_d = last_served_q ? ST_GNT0 : ST_GNT1;
          end else if (req0_act) begin
            state_d = ST_GNT0;
          end else if (req1_act) begin
            state_d = ST_GNT1;
          end
        end
      end
      ST_GNT0: begin
        if (out_empty) begin
          if (!req0_act) begin
            state_d = (req1_act && en) ? ST_GNT1 : ST_IDLE;
          end else if (hold_expired && req1_act && en) begin
            state_d = ST_GNT1;
          end
        end
      end
      ST_GNT1: begin
        if (out_empty) begin
          if (!req1_act) begin
            state_d = (req0_act && en) ? ST_GNT0 : ST_IDLE;
          end else if (hold_expired && req0_act && en) begin
            state_d = ST_GNT0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bookkeeping that follows the grant: outstanding lanes, hold timer, fairness bit.
  always_comb begin
    grant_change  = (state_d != state_q);
    gnt_d         = state_d;
    busy_d        = (state_d != ST_IDLE);
    last_served_d = last_served_q;
    hold_d        = hold_q;
    out_d         = (out_q & ~dram_valid) | (dram_en & ~dram_valid);
    if (grant_change) begin
      out_d  = 8'h00;
      hold_d = 8'h00;
      if (state_d == ST_GNT0) begin
        last_served_d = 1'b0;
      end else if (state_d == ST_GNT1) begin
        last_served_d = 1'b1;
      end
    end else if (state_q == ST_IDLE) begin
      hold_d = 8'h00;
    end else if (hold_q != 8'hFF) begin
      hold_d = hold_q + 8'h01;
    end
  end

  // Zero-latency steering between the holder and the shared DRAM port.
  always_comb begin
    dram_en      = '0;
    dram_rdwr    = 1'b0;
    dram_addr    = '0;
    data_to_dram = '0;
    req0_valid   = '0;
    req0_rdata   = '0;
    req1_valid   = '0;
    req1_rdata   = '0;
    case (state_q)
      ST_GNT0: begin
        dram_en      = req0_en;
        dram_rdwr    = req0_rdwr;
        dram_addr    = req0_addr;
        data_to_dram = req0_wdata;
        req0_valid   = dram_valid;
        req0_rdata   = data_from_dram;
      end
      ST_GNT1: begin
        dram_en      = req1_en;
        dram_rdwr    = req1_rdwr;
        dram_addr    = req1_addr;
        data_to_dram = req1_wdata;
        req1_valid   = dram_valid;
        req1_rdata   = data_from_dram;
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 2'b00;
      busy_q        <= 1'b0;
      last_served_q <= 1'b1;
      hold_q        <= 8'h00;
      out_q         <= 8'h00;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      last_served_q <= last_served_d;
      hold_q        <= hold_d;
      out_q         <= out_d;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios followed by random traffic.
// A behavioural owner/pending-set model supplies every expected value.
module tb_dram_arbiter;

  localparam int HOLD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [7:0]       req0_en, req1_en;
  logic             req0_rdwr, req1_rdwr;
  logic [7:0][63:0] req0_addr, req1_addr;
  logic [7:0][7:0]  req0_wdata, req1_wdata;
  logic [7:0]       req0_valid, req1_valid;
  logic [7:0][7:0]  req0_rdata, req1_rdata;
  logic [7:0]       dram_en;
  logic             dram_rdwr;
  logic [7:0][63:0] dram_addr;
  logic [7:0][7:0]  data_to_dram;
  logic [7:0]       dram_valid;
  logic [7:0][7:0]  data_from_dram;
  logic [1:0]       gnt;
  logic             busy;

  always #5 clk = ~clk;

  dram_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req0_en(req0_en), .req0_rdwr(req0_rdwr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_valid(req0_valid), .req0_rdata(req0_rdata),
    .req1_en(req1_en), .req1_rdwr(req1_rdwr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_valid(req1_valid), .req1_rdata(req1_rdata),
    .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr),
    .data_to_dram(data_to_dram), .dram_valid(dram_valid),
    .data_from_dram(data_from_dram), .gnt(gnt), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port, who went last, how long held, which lanes wait.
  int         m_own;
  int         m_last;
  int         m_hold;
  logic [7:0] m_pend;

  function automatic void model_reset();
    m_own  = -1;
    m_last = 1;
    m_hold = 0;
    m_pend = 8'h00;
  endfunction

  function automatic void model_step();
    bit         want[2];
    int         nxt;
    logic [7:0] lanes;
    want[0] = (req0_en != 0);
    want[1] = (req1_en != 0);
    nxt     = m_own;
    lanes   = (m_own == 0) ? req0_en : (m_own == 1) ? req1_en : 8'h00;
    if (m_own < 0) begin
      if (en) begin
        if (want[0] && want[1]) nxt = 1 - m_last;
        else if (want[0])       nxt = 0;
        else if (want[1])       nxt = 1;
      end
    end else if (m_pend == 0) begin
      if (!want[m_own])
        nxt = (want[1 - m_own] && en) ? 1 - m_own : -1;
      else if (m_hold >= HOLD && want[1 - m_own] && en)
        nxt = 1 - m_own;
    end
    for (int i = 0; i < 8; i++) begin
      if (dram_valid[i])  m_pend[i] = 1'b0;
      else if (lanes[i])  m_pend[i] = 1'b1;
    end
    if (nxt != m_own) begin
      m_pend = 8'h00;
      m_hold = 0;
      if (nxt >= 0) m_last = nxt;
    end else if (m_own >= 0 && m_hold < 255) begin
      m_hold = m_hold + 1;
    end
    m_own = nxt;
  endfunction

  function automatic logic [1:0] exp_gnt();
    return (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_comb();
    check_val("dram_en",      dram_en,      (m_own == 0) ? req0_en    : (m_own == 1) ? req1_en    : 8'h00);
    check_val("dram_rdwr",    dram_rdwr,    (m_own == 0) ? req0_rdwr  : (m_own == 1) ? req1_rdwr  : 1'b0);
    check_val("dram_addr",    dram_addr,    (m_own == 0) ? req0_addr  : (m_own == 1) ? req1_addr  : '0);
    check_val("data_to_dram", data_to_dram, (m_own == 0) ? req0_wdata : (m_own == 1) ? req1_wdata : '0);
    check_val("req0_valid",   req0_valid,   (m_own == 0) ? dram_valid     : 8'h00);
    check_val("req0_rdata",   req0_rdata,   (m_own == 0) ? data_from_dram : '0);
    check_val("req1_valid",   req1_valid,   (m_own == 1) ? dram_valid     : 8'h00);
    check_val("req1_rdata",   req1_rdata,   (m_own == 1) ? data_from_dram : '0);
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already driven.
  task automatic tick();
    if (reset) model_reset();
    #1;
    check_comb();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    check_val("gnt",  gnt,  exp_gnt());
    check_val("busy", busy, (m_own >= 0));
  endtask

  task automatic randomize_payload();
    req0_rdwr = 1'($urandom);
    req1_rdwr = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      req0_addr[i]      = {$urandom, $urandom};
      req1_addr[i]      = {$urandom, $urandom};
      req0_wdata[i]     = 8'($urandom);
      req1_wdata[i]     = 8'($urandom);
      data_from_dram[i] = 8'($urandom);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] v);
    randomize_payload();
    en         = e;
    req0_en    = r0;
    req1_en    = r1;
    dram_valid = v;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);

    // Requests during reset must not reach the DRAM port.
    drive(1'b1, 8'hFF, 8'hFF, 8'hFF);
    tick();
    check_val("rst_gnt", gnt, 2'b00);
    reset = 1'b0;

    // Simultaneous requests after reset: requester 0 first, then requester 1.
    drive(1'b1, 8'h01, 8'h01, 8'h00); tick();
    check_val("t041_first_gnt", gnt, 2'b01);
    drive(1'b1, 8'h01, 8'h01, 8'h00); tick();
    drive(1'b1, 8'h00, 8'h01, 8'h01); tick();
    check_val("t041_hold_while_pending", gnt, 2'b01);
    drive(1'b1, 8'h00, 8'h01, 8'h00); tick();
    check_val("t041_second_gnt", gnt, 2'b10);
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();
    check_val("t041_idle", gnt, 2'b00);

    // Read of lane 3 at 0x100 with data returning two cycles later.
    drive(1'b1, 8'h08, 8'h00, 8'h00); tick();
    drive(1'b1, 8'h08, 8'h00, 8'h00);
    req0_addr[3] = 64'h100;
    #1;
    check_val("t042_addr", dram_addr[3], 64'h100);
    tick();
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();
    drive(1'b1, 8'h00, 8'h00, 8'h08);
    data_from_dram[3] = 8'hAB;
    #1;
    check_val("t042_valid", req0_valid[3], 1'b1);
    check_val("t042_rdata", req0_rdata[3], 8'hAB);
    check_val("t042_req1_valid", req1_valid, 8'h00);
    tick();
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();
    check_val("t042_idle", gnt, 2'b00);

    // Preemption after HOLD cycles, postponed by one outstanding lane.
    drive(1'b1, 8'h01, 8'h00, 8'h01); tick();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 8'h01, 8'h01, (k == 4 || k == 6) ? 8'h00 : 8'h01);
      tick();
      check_val($sformatf("t043_gnt_k%0d", k), gnt, (k == 6) ? 2'b10 : 2'b01);
    end
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();

    // Holder goes quiet with lane 2 still outstanding.
    drive(1'b1, 8'h04, 8'h00, 8'h00); tick();
    drive(1'b1, 8'h04, 8'h01, 8'h00); tick();
    drive(1'b1, 8'h00, 8'h01, 8'h00); tick();
    check_val("t044_wait1", gnt, 2'b01);
    drive(1'b1, 8'h00, 8'h01, 8'h00); tick();
    check_val("t044_wait2", gnt, 2'b01);
    drive(1'b1, 8'h00, 8'h01, 8'h04); tick();
    check_val("t044_wait3", gnt, 2'b01);
    drive(1'b1, 8'h00, 8'h01, 8'h00); tick();
    check_val("t044_switch", gnt, 2'b10);
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();

    // Global enable low blocks new grants; then last_served ordering.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h01, 8'h01, 8'h00); tick();
      check_val("t045_blocked", gnt, 2'b00);
    end
    drive(1'b1, 8'h01, 8'h01, 8'h00); tick();
    check_val("t045_first", gnt, 2'b01);
    drive(1'b1, 8'h00, 8'h00, 8'h00); tick();
    drive(1'b1, 8'h01, 8'h01, 8'h00); tick();
    check_val("t045_alternate", gnt, 2'b10);

    // Asynchronous reset with three lanes outstanding under GNT1.
    drive(1'b1, 8'h01, 8'h07, 8'h00); tick();
    check_val("t046_pre", gnt, 2'b10);
    drive(1'b1, 8'h01, 8'h07, 8'h05);
    #2;
    reset = 1'b1;
    #1;
    check_val("t046_gnt", gnt, 2'b00);
    check_val("t046_busy", busy, 1'b0);
    check_val("t046_dram_en", dram_en, 8'h00);
    check_val("t046_req1_valid", req1_valid, 8'h00);
    model_reset();
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h00, 8'h00, 8'h07); tick();
    check_val("t046_stale_valid", gnt, 2'b00);
    drive(1'b1, 8'h00, 8'h01, 8'h00); tick();
    check_val("t046_regrant", gnt, 2'b10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom),
            ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom),
            ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom & $urandom));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
